// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined multiplier and the stages that consume it.
// mult_latency() lets reduction and round-control FSMs size their own delay lines.
package mult_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  function automatic int mult_latency(input int width, input int limb);
    return 32'sd1 + clog2(width / limb);
  endfunction

endpackage

// File: rtl/mult_tree_level.sv
// One registered level of the partial-product reduction tree: N_IN operands
// are folded pairwise into N_IN/2 sums, the odd operand weighted by 2^SHIFT.
module mult_tree_level
  import mult_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int SHIFT = 16,
  parameter int W     = 32,
  parameter int TAG_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic                      i_valid,
  input  logic [TAG_W-1:0]          i_tag,
  input  logic [N_IN-1:0][W-1:0]    i_data,
  output logic                      o_valid,
  output logic [TAG_W-1:0]          o_tag,
  output logic [N_IN/2-1:0][W-1:0]  o_data
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT-1:0][W-1:0] w_sum;
  logic [N_OUT-1:0][W-1:0] r_data;
  logic                    r_valid;
  logic [TAG_W-1:0]        r_tag;

  // Pairwise shift-add; width W already holds the full product, so nothing is lost.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_sum[j] = i_data[2*j] + (i_data[2*j+1] << SHIFT);
    end
  end

  // Level register; freezes together with the rest of the pipeline when i_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_en) begin
      r_data  <= w_sum;
      r_valid <= i_valid;
      r_tag   <= i_tag;
    end else begin
      r_data  <= r_data;
      r_valid <= r_valid;
      r_tag   <= r_tag;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_tag   = r_tag;

endmodule

// File: rtl/mult_pipe_param.sv
// Fully pipelined exact unsigned multiplier: limb partial products, then a
// registered log2(NLIMB)-deep shift-add tree, with valid/ready and a tag sidecar.
module mult_pipe_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int LIMB  = 16,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int NLIMB  = WIDTH / LIMB;
  localparam int LEVELS = clog2(NLIMB);
  localparam int PW     = 2 * WIDTH;

  if (((WIDTH % LIMB) != 0) || (NLIMB < 2) || ((NLIMB & (NLIMB - 1)) != 0)) begin : g_param_check
    $error("mult_pipe_param: WIDTH must be a multiple of LIMB and WIDTH/LIMB a power of two >= 2");
  end

  logic                    w_en;
  logic [NLIMB-1:0][PW-1:0] w_pp;
  logic [NLIMB-1:0][PW-1:0] r_pp;
  logic                    r_valid0;
  logic [TAG_W-1:0]        r_tag0;

  // A stalled output stalls everything, so no bubble is ever squeezed out.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Partial products of A against each limb of B, zero-extended to full width.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < NLIMB; i++) begin
      w_pp[i] = PW'(in_a) * PW'(in_b[LIMB*i +: LIMB]);
    end
  end

  // Stage 0 register: partial products plus the valid/tag of the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pp     <= '0;
      r_valid0 <= 1'b0;
      r_tag0   <= '0;
    end else if (w_en) begin
      r_pp     <= w_pp;
      r_valid0 <= in_valid;
      r_tag0   <= in_tag;
    end else begin
      r_pp     <= r_pp;
      r_valid0 <= r_valid0;
      r_tag0   <= r_tag0;
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int N_IN = NLIMB >> (k - 1);

    logic [N_IN-1:0][PW-1:0]   w_in_data;
    logic                      w_in_valid;
    logic [TAG_W-1:0]          w_in_tag;
    logic [N_IN/2-1:0][PW-1:0] w_data;
    logic                      w_valid;
    logic [TAG_W-1:0]          w_tag;

    if (k == 1) begin : g_src
      assign w_in_data  = r_pp;
      assign w_in_valid = r_valid0;
      assign w_in_tag   = r_tag0;
    end else begin : g_src
      assign w_in_data  = g_lvl[k-1].w_data;
      assign w_in_valid = g_lvl[k-1].w_valid;
      assign w_in_tag   = g_lvl[k-1].w_tag;
    end

    // Level k merges operands LIMB*2^(k-1) bits apart.
    mult_tree_level #(
      .N_IN  (N_IN),
      .SHIFT (LIMB << (k - 1)),
      .W     (PW),
      .TAG_W (TAG_W)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_en),
      .i_valid (w_in_valid),
      .i_tag   (w_in_tag),
      .i_data  (w_in_data),
      .o_valid (w_valid),
      .o_tag   (w_tag),
      .o_data  (w_data)
    );
  end

  assign out_product = g_lvl[LEVELS].w_data[0];
  assign out_valid   = g_lvl[LEVELS].w_valid;
  assign out_tag     = g_lvl[LEVELS].w_tag;

endmodule

// File: doc/mult_pipe_param.md
Name: mult_pipe_param

Overview:
- Parametrised, fully pipelined unsigned multiplier for wide field arithmetic (MiMC / BN254 datapath).
- Splits operand B into LIMB-bit limbs, forms all partial products in one stage, then reduces them through a registered binary shift-add tree.
- Adds a valid/ready handshake with full-pipeline backpressure and a tag sidecar, so the block can feed the modular-reduction and round-control stages directly.

Parameters:
- WIDTH, 256, operand width in bits. WIDTH % LIMB == 0.
- LIMB, 16, limb width of operand B. NLIMB = WIDTH/LIMB must be a power of two, >= 2.
- TAG_W, 8, width of the user tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts the request this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier (limb-split).
- in_tag  in  TAG_W  opaque tag, returned with the result.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_product  out  2*WIDTH  in_a * in_b, exact, unsigned.
- out_tag  out  TAG_W  tag of that result.

Behaviour:
- Latency LAT = 1 + log2(NLIMB) cycles from acceptance to out_valid when not stalled. Default is 5.
- Stage 0 registers pp[i] = in_a * in_b[LIMB*i +: LIMB] for i in 0..NLIMB-1. Each is zero-extended to 2*WIDTH.
- Tree level k (k = 1..log2(NLIMB)) registers s[j] = s_prev[2j] + (s_prev[2j+1] << (LIMB * 2^(k-1))). Sums are 2*WIDTH wide. No bits are truncated, because the final value is less than 2^(2*WIDTH).
- One valid bit and one tag register travel with each stage.
- Advance enable: en = !out_valid || out_ready. Every stage, including the output stage, loads only when en=1. When en=0 the whole pipeline freezes: data, tag and valid are held.
- in_ready = en, combinational from out_valid and out_ready. A transfer happens when in_valid && in_ready.
- If en=1 and in_valid=0, a bubble enters stage 0 (valid=0). Bubbles propagate and are never squeezed out.
- Throughput is one operation per cycle while out_ready stays high. Results leave in acceptance order.
- out_product and out_tag stay stable while out_valid && !out_ready.
- out_product and out_tag are don't-care when out_valid=0, but must not be X after reset.
- Reset (async assert, sync deassert handled upstream): all valid bits = 0, out_valid = 0, out_product = 0, out_tag = 0. Stage data registers also clear to 0.
- Reset mid-operation discards all in-flight work. No result from before reset may appear afterwards.
- in_ready is 1 in the first cycle after reset deasserts.
- Boundaries:
  - in_a = 0 or in_b = 0 gives 0.
  - All-ones operands give the exact full-width square.
  - A simultaneous input accept and output pop with en=1 is legal and loses nothing.
  - out_ready toggling every cycle must still deliver every result exactly once.
- Elaboration: a $error or static assertion fires if WIDTH % LIMB != 0 or NLIMB is not a power of two.

Decomposition:
- Shared package mult_pkg holds:
  - function clog2;
  - localparam function mult_latency(WIDTH, LIMB) = 1 + clog2(WIDTH/LIMB), exported for the reduction and control FSMs.
- Sub-module mult_tree_level, instantiated log2(NLIMB) times via generate:
  - parameters N_IN, SHIFT, W;
  - registered pairwise shift-add with enable, carrying valid and tag.
- The top holds the partial-product stage, the handshake logic and the generate loop.

Test Plan:
- Single op, defaults: in_a = in_b = 2^256-1, tag 0x5A → out_valid exactly 5 cycles after acceptance, out_product = 0xFFFF…FFFE 0000…0001 (255 ones, one 0, 255 zeros, one 1), out_tag 0x5A.
- Streaming: 64 back-to-back random pairs, out_ready=1 → in_ready never drops, 64 results in order matching the reference model, the first at cycle 5, then one per cycle.
- Backpressure: stream 20 ops with out_ready held low for cycles 8-15 → in_ready low exactly while out_valid && !out_ready, outputs stable, no loss or duplicate, tags in order.
- Random in_valid/out_ready at 50% each over 10k ops → scoreboard match, and accepted count == delivered count at drain.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle → out_valid=0, out_product=0, out_tag=0 immediately; no stale result afterwards; a new op 3×7 gives 21 after 5 cycles.
- Variant WIDTH=64, LIMB=16: 0xFFFF_FFFF_FFFF_FFFF × 2 → 0x1_FFFF_FFFF_FFFF_FFFE with latency 3.
